// File: rtl/maze_step_controller.sv
// Purpose: left-hand-rule maze walker; moves one STEP per video frame.
// Latency: frame_end -> probe_req 1 cycle; probe_ack -> step_pulse 2 cycles.
// Backpressure: none; a frame_end arriving while a step is in flight is dropped.
module maze_step_controller #(
   parameter int unsigned STEP    = 8,
   parameter int unsigned H_MAX   = 719,
   parameter int unsigned V_MAX   = 287,
   parameter int unsigned EXIT_V  = 280,
   parameter int unsigned TIMEOUT = 63
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       video_frame_valid,
   input  logic       params_valid,
   input  logic [9:0] start_x,
   input  logic [9:0] start_y,
   output logic       probe_req,
   input  logic       probe_ack,
   input  logic [3:0] probe_open,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic [3:0] heading,
   output logic       step_pulse,
   output logic       probe_timeout,
   output logic       done,
   output logic       stuck
);

   // Wide enough to hold TIMEOUT itself without wrapping.
   localparam int unsigned CW = $clog2(TIMEOUT + 1) + 1;

   // Direction encoding shared by heading and probe_open: {N,E,S,W}.
   localparam logic [3:0] DIR_N = 4'b1000;
   localparam logic [3:0] DIR_E = 4'b0100;
   localparam logic [3:0] DIR_S = 4'b0010;
   localparam logic [3:0] DIR_W = 4'b0001;

   // Boundary tests use 11 bits so pos + STEP can never wrap.
   localparam logic [10:0] STEP_11  = 11'(STEP);
   localparam logic [10:0] H_MAX_11 = 11'(H_MAX);
   localparam logic [10:0] V_MAX_11 = 11'(V_MAX);
   localparam logic [9:0]  STEP_10  = 10'(STEP);
   localparam logic [9:0]  EXIT_10  = 10'(EXIT_V);
   localparam logic [CW-1:0] TMO_CW = CW'(TIMEOUT);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARMED  = 3'd1,
      ST_PROBE  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DECIDE = 3'd4,
      ST_DONE   = 3'd5,
      ST_STUCK  = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic            fv_q;
   logic [9:0]      pos_x_q, pos_x_d;
   logic [9:0]      pos_y_q, pos_y_d;
   logic [3:0]      heading_q, heading_d;
   logic [3:0]      open_q, open_d;
   logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
   logic            step_q, step_d;
   logic            timeout_q, timeout_d;

   logic            frame_end;
   logic [10:0]     px_11, py_11;
   logic [3:0]      bound_ok;
   logic [3:0]      open_masked;
   logic [3:0]      dir_left, dir_right, dir_back;
   logic [3:0]      new_heading;
   logic            any_open;
   logic [9:0]      next_x, next_y;

   // Falling edge of the frame-active level marks the end of a frame.
   assign frame_end = fv_q & ~video_frame_valid;

   // Close any direction whose move would leave the legal coordinate range.
   assign px_11    = {1'b0, pos_x_q};
   assign py_11    = {1'b0, pos_y_q};
   assign bound_ok = {py_11 >= STEP_11,
                      (px_11 + STEP_11) <= H_MAX_11,
                      (py_11 + STEP_11) <= V_MAX_11,
                      px_11 >= STEP_11};
   assign open_masked = probe_open & bound_ok;

   // Relative directions: with {N,E,S,W} ordering, left rotates one bit up.
   assign dir_left  = {heading_q[2:0], heading_q[3]};
   assign dir_right = {heading_q[0], heading_q[3:1]};
   assign dir_back  = {heading_q[1:0], heading_q[3:2]};

   // Left-hand rule: left, straight, right, back; first open one wins.
   always_comb begin
      new_heading = heading_q;
      any_open    = 1'b1;
      if ((dir_left & open_q) != 4'b0000) begin
         new_heading = dir_left;
      end else if ((heading_q & open_q) != 4'b0000) begin
         new_heading = heading_q;
      end else if ((dir_right & open_q) != 4'b0000) begin
         new_heading = dir_right;
      end else if ((dir_back & open_q) != 4'b0000) begin
         new_heading = dir_back;
      end else begin
         any_open = 1'b0;
      end
   end

   // Target position for the chosen heading; masking already keeps it in range.
   always_comb begin
      next_x = pos_x_q;
      next_y = pos_y_q;
      case (new_heading)
         DIR_N:   next_y = pos_y_q - STEP_10;
         DIR_S:   next_y = pos_y_q + STEP_10;
         DIR_E:   next_x = pos_x_q + STEP_10;
         DIR_W:   next_x = pos_x_q - STEP_10;
         default: begin
            next_x = pos_x_q;
            next_y = pos_y_q;
         end
      endcase
   end

   // Next-state and registered-output logic for the step sequencer.
   always_comb begin
      state_d    = state_q;
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      heading_d  = heading_q;
      open_d     = open_q;
      wait_cnt_d = wait_cnt_q;
      step_d     = 1'b0;
      timeout_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (params_valid) begin
               pos_x_d   = start_x;
               pos_y_d   = start_y;
               heading_d = DIR_S;
               state_d   = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (!params_valid) begin
               state_d = ST_IDLE;
            end else if (frame_end) begin
               state_d = ST_PROBE;
            end
         end
         ST_PROBE: begin
            if (!params_valid) begin
               state_d = ST_IDLE;
            end else begin
               wait_cnt_d = '0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!params_valid) begin
               state_d = ST_IDLE;
            end else if (probe_ack) begin
               open_d  = open_masked;
               state_d = ST_DECIDE;
            end else if ((wait_cnt_q + 1'b1) == TMO_CW) begin
               // Counter reaches TIMEOUT this cycle: give up, keep position.
               timeout_d = 1'b1;
               state_d   = ST_ARMED;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ST_DECIDE: begin
            if (any_open) begin
               heading_d = new_heading;
               pos_x_d   = next_x;
               pos_y_d   = next_y;
               step_d    = 1'b1;
               state_d   = (next_y >= EXIT_10) ? ST_DONE : ST_ARMED;
            end else begin
               state_d = ST_STUCK;
            end
         end
         ST_DONE, ST_STUCK: begin
            if (!params_valid) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any pending move at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         fv_q       <= 1'b0;
         pos_x_q    <= '0;
         pos_y_q    <= '0;
         heading_q  <= DIR_S;
         open_q     <= '0;
         wait_cnt_q <= '0;
         step_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fv_q       <= video_frame_valid;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         heading_q  <= heading_d;
         open_q     <= open_d;
         wait_cnt_q <= wait_cnt_d;
         step_q     <= step_d;
         timeout_q  <= timeout_d;
      end
   end

   assign probe_req     = (state_q == ST_PROBE);
   assign done          = (state_q == ST_DONE);
   assign stuck         = (state_q == ST_STUCK);
   assign pos_x         = pos_x_q;
   assign pos_y         = pos_y_q;
   assign heading       = heading_q;
   assign step_pulse    = step_q;
   assign probe_timeout = timeout_q;

endmodule
